seg7_scan_driver: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display. It latches a packed hexadecimal value plus decimal points into a shadow register and decodes each nibble to standard hex glyphs (0-9, A, b, C, d, E, F). It scans one digit at a time with a programmable dwell period, a one-cycle anode dead time and optional leading-zero blanking. It sits between the datapath that produces the value and the board's segment/anode pins.

---
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment scan driver with shadow register, one-cycle
// anode dead time per slot and optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  LOAD,
  input  logic                  BLANK_LZ,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     AN
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [4*DIGITS-1:0]    r_val;
  logic [DIGITS-1:0]      r_dp;
  logic                   r_blank;
  logic [6:0]             r_seg;
  logic                   r_dpo;
  logic [DIGITS-1:0]      r_an;

  logic [3:0]             w_nib;
  logic                   w_dpsel;
  logic                   w_blank_sel;
  logic                   w_sfx_zero;
  logic [DIGITS-1:0]      w_lz;
  logic [DIGITS-1:0]      w_onehot;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    w_nib       = '0;
    w_dpsel     = 1'b0;
    w_blank_sel = 1'b0;
    w_sfx_zero  = 1'b1;
    w_lz        = '0;
    w_onehot    = '0;
    // Walk from the most significant digit down: a digit is a leading zero
    // while every digit at or above it has a zero nibble and no decimal point.
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_sfx_zero = w_sfx_zero & (r_val[4*(DIGITS-1-k) +: 4] == 4'h0)
                              & ~r_dp[DIGITS-1-k];
      w_lz[DIGITS-1-k] = r_blank & w_sfx_zero & (k != DIGITS - 1);
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (32'(r_idx) == i) begin
        w_nib       = r_val[4*i +: 4];
        w_dpsel     = r_dp[i];
        w_blank_sel = w_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_val   <= '0;
      r_dp    <= '0;
      r_blank <= 1'b0;
      r_seg   <= '0;
      r_dpo   <= 1'b0;
      r_an    <= '0;
    end else begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (LOAD) begin
        r_val   <= VALUE;
        r_dp    <= DP_IN;
        r_blank <= BLANK_LZ;
      end

      if (r_cnt == '0) begin
        r_seg <= '0;
        r_dpo <= 1'b0;
        r_an  <= '0;
      end else begin
        r_an  <= w_onehot;
        r_seg <= w_blank_sel ? 7'h00 : glyph(w_nib);
        r_dpo <= ~w_blank_sel & w_dpsel;
      end
    end
  end

  assign SEG = ACTIVE_LOW ? ~r_seg : r_seg;
  assign DP  = ACTIVE_LOW ? ~r_dpo : r_dpo;
  assign AN  = ACTIVE_LOW ? ~r_an  : r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a 4-digit/4-cycle active-high instance
// and a 1-digit/2-cycle active-low instance.
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] VALUE = '0;
  logic [3:0]  DP_IN = '0;
  logic        LOAD = 1'b0;
  logic        BLANK_LZ = 1'b0;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  AN;

  logic        RST2 = 1'b1;
  logic [3:0]  VALUE2 = '0;
  logic [0:0]  DP_IN2 = '0;
  logic        LOAD2 = 1'b0;
  logic        BLANK_LZ2 = 1'b0;
  logic [6:0]  SEG2;
  logic        DP2;
  logic [0:0]  AN2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .DP_IN(DP_IN), .LOAD(LOAD),
    .BLANK_LZ(BLANK_LZ), .SEG(SEG), .DP(DP), .AN(AN)
  );

  seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(2), .ACTIVE_LOW(1'b1)) u_lo (
    .CLK(CLK), .RST(RST2), .VALUE(VALUE2), .DP_IN(DP_IN2), .LOAD(LOAD2),
    .BLANK_LZ(BLANK_LZ2), .SEG(SEG2), .DP(DP2), .AN(AN2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an,
                         input logic [6:0] seg, input logic dp);
    chk({tag, " AN"},  32'(AN),  32'(an));
    chk({tag, " SEG"}, 32'(SEG), 32'(seg));
    chk({tag, " DP"},  32'(DP),  32'(dp));
  endtask

  // Expects the DUT at cnt=0, idx=0. Loads on the first (DEAD) edge, then
  // scrambles the inputs to show unsampled changes are ignored.
  // segs packs one glyph per byte: {d3, d2, d1, d0}.
  task automatic run_frame(input string tag, input logic [15:0] v, input logic [3:0] dp,
                           input logic blz, input logic [31:0] segs, input logic [3:0] dps);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (d == 0 && c == 0) begin
          VALUE = v; DP_IN = dp; BLANK_LZ = blz; LOAD = 1'b1;
        end
        tick();
        LOAD = 1'b0; VALUE = ~v; DP_IN = ~dp; BLANK_LZ = ~blz;
        if (c == 0) chk_out($sformatf("%s d%0d dead", tag, d), 4'b0000, 7'h00, 1'b0);
        else chk_out($sformatf("%s d%0d c%0d", tag, d, c), 4'(1 << d),
                     segs[8*d +: 7], dps[d]);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) tick();
    chk_out("reset", 4'b0000, 7'h00, 1'b0);
    RST = 1'b0;

    run_frame("scan1234",   16'h1234, 4'b0000, 1'b0, 32'h065B4F66, 4'b0000);
    run_frame("scan1234b",  16'h1234, 4'b0000, 1'b0, 32'h065B4F66, 4'b0000);
    run_frame("sweep0",     16'h3210, 4'b1010, 1'b0, 32'h4F5B063F, 4'b1010);
    run_frame("sweep1",     16'h7654, 4'b0000, 1'b0, 32'h077D6D66, 4'b0000);
    run_frame("sweep2",     16'hBA98, 4'b0000, 1'b0, 32'h7C776F7F, 4'b0000);
    run_frame("sweep3",     16'hFEDC, 4'b0001, 1'b0, 32'h71795E39, 4'b0001);
    run_frame("lz0050",     16'h0050, 4'b0000, 1'b1, 32'h00006D3F, 4'b0000);
    run_frame("lz0050dp",   16'h0050, 4'b0100, 1'b1, 32'h003F6D3F, 4'b0100);
    run_frame("lz0500",     16'h0500, 4'b0000, 1'b1, 32'h006D3F3F, 4'b0000);
    run_frame("lzall0",     16'h0000, 4'b0000, 1'b1, 32'h0000003F, 4'b0000);
    run_frame("nolz0",      16'h0000, 4'b0000, 1'b0, 32'h3F3F3F3F, 4'b0000);
    run_frame("pre_mid",    16'h1234, 4'b0000, 1'b0, 32'h065B4F66, 4'b0000);

    // Mid-slot LOAD during digit 1 drive.
    repeat (4) tick();
    tick();
    chk_out("mid d1 dead", 4'b0000, 7'h00, 1'b0);
    tick();
    chk_out("mid d1 c1", 4'b0010, 7'h4F, 1'b0);
    VALUE = 16'hFFFF; DP_IN = 4'b0000; BLANK_LZ = 1'b0; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk_out("mid load edge", 4'b0010, 7'h4F, 1'b0);
    tick();
    chk_out("mid new glyph", 4'b0010, 7'h71, 1'b0);
    tick();
    chk_out("mid d2 dead", 4'b0000, 7'h00, 1'b0);
    tick();
    chk_out("mid d2 c1", 4'b0100, 7'h71, 1'b0);

    // Reset pulse mid-frame clears shadow and restarts at digit 0.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk_out("rst pulse", 4'b0000, 7'h00, 1'b0);
    tick();
    chk_out("rst dead", 4'b0000, 7'h00, 1'b0);
    tick();
    chk_out("rst d0", 4'b0001, 7'h3F, 1'b0);

    // Active-low, single digit, two-cycle slot.
    RST2 = 1'b1;
    repeat (2) tick();
    chk("lo rst AN",  32'(AN2),  32'h1);
    chk("lo rst SEG", 32'(SEG2), 32'h7F);
    chk("lo rst DP",  32'(DP2),  32'h1);
    RST2 = 1'b0; VALUE2 = 4'h5; DP_IN2 = 1'b0; LOAD2 = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      LOAD2 = 1'b0; VALUE2 = 4'hA;
      chk($sformatf("lo dead%0d AN", n),  32'(AN2),  32'h1);
      chk($sformatf("lo dead%0d SEG", n), 32'(SEG2), 32'h7F);
      chk($sformatf("lo dead%0d DP", n),  32'(DP2),  32'h1);
      tick();
      chk($sformatf("lo drv%0d AN", n),  32'(AN2),  32'h0);
      chk($sformatf("lo drv%0d SEG", n), 32'(SEG2), 32'h12);
      chk($sformatf("lo drv%0d DP", n),  32'(DP2),  32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
